sequential_16bit_checker: RTL and testbench



---
 rtl/sequential_16bit_checker.sv | 246 ++++++++++++++++++++++++
 tb/tb_sequential_16bit_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sequential_16bit_checker.sv
// ---------------------------------------------------------------------------
// sequential_16bit_checker
//
// Receive-side loopback checker for the 16-bit free-running counter pattern
// that is driven onto the west-edge IO pads. Each enabled clock it samples the
// 16 pad inputs through a short register pipeline. It locks onto an
// incrementing sequence and then counts every deviation from it. It also
// counts 0xFFFF -> 0x0000 pattern wraps.
//
// Parameters
//   SYNC_STAGES : input register stages before the compare (1..3)
//   LOCK_COUNT  : consecutive correct increments needed to lock (1..15)
//   LOSS_COUNT  : consecutive mismatches while locked that drop lock (1..15)
//
// Ports
//   CLK         in   fabric global clock, rising edge
//   resetn      in   asynchronous active-low reset
//   pad_i       in   16 pad O inputs, pad_i[15] = Tile_X0Y1_A_O ...
//                    pad_i[0] = Tile_X0Y8_B_O
//   sample_en   in   the word entering the pipeline this cycle is valid
//   clear       in   synchronous clear of err_count, wrap_count, err_sticky
//   locked      out  high while the checker is in the LOCKED state
//   err_pulse   out  one-cycle pulse per mismatching sample while locked
//   err_sticky  out  set by any error, cleared by clear or reset
//   err_count   out  mismatches while locked, saturating at 0xFFFF
//   wrap_count  out  0xFFFF -> 0x0000 transitions while locked, modulo 2^16
//   last_sample out  most recent valid sample
//
// All outputs come straight from registers. The latency from a pad change to
// last_sample / err_pulse is SYNC_STAGES + 1 cycles. clear acts on the very
// next edge and is not pipelined.
// ---------------------------------------------------------------------------
module sequential_16bit_checker #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_COUNT  = 3
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [15:0] pad_i,
    input  logic        sample_en,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic        err_sticky,
    output logic [15:0] err_count,
    output logic [15:0] wrap_count,
    output logic [15:0] last_sample
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]  LOCK_LIMIT = 4'(LOCK_COUNT);
    localparam logic [3:0]  LOSS_LIMIT = 4'(LOSS_COUNT);
    localparam logic [15:0] ALL_ONES   = 16'hFFFF;

    // Saturating 16-bit increment, so the error counter sticks at full scale.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == ALL_ONES) begin
            result = ALL_ONES;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // -----------------------------------------------------------------------
    // Input pipeline
    // The enable travels beside the data so a sample and its valid flag reach
    // the compare together.
    // -----------------------------------------------------------------------
    logic [15:0]            sync_data_r [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_en_r;

    // Input shift registers for pad data and the aligned sample enable.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_data_r[i] <= 16'h0000;
            end
            sync_en_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_data_r[0] <= pad_i;
            sync_en_r[0]   <= sample_en;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_data_r[i] <= sync_data_r[i-1];
                sync_en_r[i]   <= sync_en_r[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tracking state
    // -----------------------------------------------------------------------
    state_t      state_r;
    logic [15:0] expected_r;
    logic [3:0]  run_r;
    logic        locked_r;
    logic        err_pulse_r;
    logic        err_sticky_r;
    logic [15:0] err_count_r;
    logic [15:0] wrap_count_r;
    logic [15:0] last_sample_r;

    logic [15:0] sample_s;
    logic        valid_s;
    logic        match_s;
    logic [3:0]  run_inc_s;

    state_t      state_n_s;
    logic [15:0] expected_n_s;
    logic [3:0]  run_n_s;
    logic        err_hit_s;
    logic        wrap_hit_s;
    logic [15:0] err_count_n_s;
    logic [15:0] wrap_count_n_s;
    logic        err_sticky_n_s;
    logic [15:0] last_sample_n_s;

    assign sample_s  = sync_data_r[SYNC_STAGES-1];
    assign valid_s   = sync_en_r[SYNC_STAGES-1];
    assign match_s   = (sample_s == expected_r);
    assign run_inc_s = run_r + 4'd1;

    // Next-state logic: seed, acquire and locked tracking of the sequence.
    always_comb begin
        state_n_s    = state_r;
        expected_n_s = expected_r;
        run_n_s      = run_r;
        err_hit_s    = 1'b0;
        wrap_hit_s   = 1'b0;
        if (valid_s) begin
            // Every valid sample reseeds the prediction, so a single bad
            // word costs at most two errors.
            expected_n_s = sample_s + 16'd1;
            case (state_r)
                ST_SEED: begin
                    run_n_s   = 4'd0;
                    state_n_s = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match_s) begin
                        if (run_inc_s >= LOCK_LIMIT) begin
                            run_n_s   = 4'd0;
                            state_n_s = ST_LOCKED;
                        end else begin
                            run_n_s = run_inc_s;
                        end
                    end else begin
                        run_n_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        run_n_s    = 4'd0;
                        wrap_hit_s = (last_sample_r == ALL_ONES) &&
                                     (sample_s == 16'h0000);
                    end else begin
                        err_hit_s = 1'b1;
                        if (run_inc_s >= LOSS_LIMIT) begin
                            run_n_s   = 4'd0;
                            state_n_s = ST_ACQUIRE;
                        end else begin
                            run_n_s = run_inc_s;
                        end
                    end
                end
                default: begin
                    run_n_s   = 4'd0;
                    state_n_s = ST_SEED;
                end
            endcase
        end else begin
            state_n_s    = state_r;
            expected_n_s = expected_r;
            run_n_s      = run_r;
        end
    end

    // Counter and status next values; an event in the clear cycle survives.
    always_comb begin
        err_count_n_s   = err_count_r;
        wrap_count_n_s  = wrap_count_r;
        err_sticky_n_s  = err_sticky_r;
        last_sample_n_s = last_sample_r;
        if (clear) begin
            err_count_n_s  = {15'd0, err_hit_s};
            wrap_count_n_s = {15'd0, wrap_hit_s};
            err_sticky_n_s = err_hit_s;
        end else begin
            if (err_hit_s) begin
                err_count_n_s = sat_inc16(err_count_r);
            end else begin
                err_count_n_s = err_count_r;
            end
            wrap_count_n_s = wrap_count_r + {15'd0, wrap_hit_s};
            err_sticky_n_s = err_sticky_r | err_hit_s;
        end
        if (valid_s) begin
            last_sample_n_s = sample_s;
        end else begin
            last_sample_n_s = last_sample_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_SEED;
            expected_r    <= 16'h0000;
            run_r         <= 4'd0;
            locked_r      <= 1'b0;
            err_pulse_r   <= 1'b0;
            err_sticky_r  <= 1'b0;
            err_count_r   <= 16'h0000;
            wrap_count_r  <= 16'h0000;
            last_sample_r <= 16'h0000;
        end else begin
            state_r       <= state_n_s;
            expected_r    <= expected_n_s;
            run_r         <= run_n_s;
            locked_r      <= (state_n_s == ST_LOCKED);
            err_pulse_r   <= err_hit_s;
            err_sticky_r  <= err_sticky_n_s;
            err_count_r   <= err_count_n_s;
            wrap_count_r  <= wrap_count_n_s;
            last_sample_r <= last_sample_n_s;
        end
    end

    assign locked      = locked_r;
    assign err_pulse   = err_pulse_r;
    assign err_sticky  = err_sticky_r;
    assign err_count   = err_count_r;
    assign wrap_count  = wrap_count_r;
    assign last_sample = last_sample_r;

endmodule

// File: tb/tb_sequential_16bit_checker.sv
// ---------------------------------------------------------------------------
// Testbench for sequential_16bit_checker (default parameters).
// Each driven word is pushed to a scoreboard together with the error and
// lock status that word must produce. The entry is popped when that word
// reaches the compare (two pipeline stages later), and last_sample,
// err_pulse and locked are checked. Counter values are checked directly at
// the points of interest.
// ---------------------------------------------------------------------------
module tb_sequential_16bit_checker;

    logic        CLK;
    logic        resetn;
    logic [15:0] pad_i;
    logic        sample_en;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic        err_sticky;
    logic [15:0] err_count;
    logic [15:0] wrap_count;
    logic [15:0] last_sample;

    sequential_16bit_checker dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .pad_i       (pad_i),
        .sample_en   (sample_en),
        .clear       (clear),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .wrap_count  (wrap_count),
        .last_sample (last_sample)
    );

    typedef struct {
        logic        en;
        logic [15:0] data;
        logic        err;
        int          lck;   // 0 / 1, or 2 when not checked
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] exp_last;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] v;
    logic [15:0] p;
    logic        e;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_idle();
        sb_t ent;
        ent.en   = 1'b0;
        ent.data = 16'h0000;
        ent.err  = 1'b0;
        ent.lck  = 0;
        sb_q.push_back(ent);
    endtask

    // Drive one cycle, then check the entry whose word is compared at this edge.
    task automatic step(input logic [15:0] pad, input logic en, input logic clr,
                        input logic exp_err, input int exp_lck);
        sb_t ent;
        pad_i     = pad;
        sample_en = en;
        clear     = clr;
        ent.en    = en;
        ent.data  = pad;
        ent.err   = exp_err;
        ent.lck   = exp_lck;
        sb_q.push_back(ent);
        @(posedge CLK);
        #1;
        clear = 1'b0;
        ent = sb_q.pop_front();
        if (ent.en) begin
            exp_last = ent.data;
        end
        chk("last_sample", last_sample, exp_last);
        chk("err_pulse", {15'd0, err_pulse}, {15'd0, ent.err});
        if (ent.lck != 2) begin
            chk("locked", {15'd0, locked}, 16'(ent.lck));
        end
    endtask

    task automatic flush(input int n, input int exp_lck);
        for (int i = 0; i < n; i++) begin
            step(16'h0000, 1'b0, 1'b0, 1'b0, exp_lck);
        end
    endtask

    // Assert reset, check outputs clear at once, release on a falling edge.
    task automatic do_reset();
        resetn    = 1'b0;
        pad_i     = 16'h0000;
        sample_en = 1'b0;
        clear     = 1'b0;
        #1;
        chk("rst_locked", {15'd0, locked}, 16'h0000);
        chk("rst_err_pulse", {15'd0, err_pulse}, 16'h0000);
        chk("rst_err_sticky", {15'd0, err_sticky}, 16'h0000);
        chk("rst_err_count", err_count, 16'h0000);
        chk("rst_wrap_count", wrap_count, 16'h0000);
        chk("rst_last_sample", last_sample, 16'h0000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        sb_q.delete();
        push_idle();
        push_idle();
        exp_last = 16'h0000;
    endtask

    initial begin
        resetn    = 1'b0;
        pad_i     = 16'h0000;
        sample_en = 1'b0;
        clear     = 1'b0;
        exp_last  = 16'h0000;

        // Clean count from 0: locks after the seed plus four increments.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(16'(k), 1'b1, 1'b0, 1'b0, (k >= 4) ? 1 : 0);
        end
        chk("clean_err_count", err_count, 16'h0000);

        // Wrap through 0xFFFF -> 0x0000 while locked.
        do_reset();
        for (int k = 0; k < 33; k++) begin
            v = 16'hFFF0 + 16'(k);
            step(v, 1'b1, 1'b0, 1'b0, (k >= 4) ? 1 : 0);
        end
        flush(2, 1);
        chk("wrap_count", wrap_count, 16'h0001);
        chk("wrap_err_count", err_count, 16'h0000);
        chk("wrap_locked", {15'd0, locked}, 16'h0001);

        // Single glitch: 0x0100 replaced by 0x0500 costs two errors.
        do_reset();
        for (int k = 0; k < 33; k++) begin
            v = 16'h00F0 + 16'(k);
            p = (v == 16'h0100) ? 16'h0500 : v;
            e = (v == 16'h0100) || (v == 16'h0101);
            step(p, 1'b1, 1'b0, e, (k >= 4) ? 1 : 0);
        end
        flush(2, 1);
        chk("glitch_err_count", err_count, 16'h0002);
        chk("glitch_err_sticky", {15'd0, err_sticky}, 16'h0001);
        chk("glitch_locked", {15'd0, locked}, 16'h0001);
        chk("glitch_wrap_count", wrap_count, 16'h0000);

        // Plain clear on an idle cycle.
        step(16'h0000, 1'b0, 1'b1, 1'b0, 1);
        chk("clear_err_count", err_count, 16'h0000);
        chk("clear_err_sticky", {15'd0, err_sticky}, 16'h0000);

        // Stuck bus: three errors, lock lost on the third, relock after four.
        for (int k = 0; k < 6; k++) begin
            step(16'h1234, 1'b1, 1'b0, (k < 3) ? 1'b1 : 1'b0, (k < 2) ? 1 : 0);
        end
        for (int k = 0; k < 7; k++) begin
            v = 16'h1235 + 16'(k);
            step(v, 1'b1, 1'b0, 1'b0, (k >= 3) ? 1 : 0);
        end
        flush(2, 1);
        chk("stuck_err_count", err_count, 16'h0003);
        chk("stuck_relocked", {15'd0, locked}, 16'h0001);

        // Clear on the edge where a mismatch reaches compare.
        step(16'h123C, 1'b1, 1'b0, 1'b0, 1);
        step(16'h7777, 1'b1, 1'b0, 1'b1, 1);
        step(16'h123E, 1'b1, 1'b0, 1'b1, 1);
        step(16'h123F, 1'b1, 1'b1, 1'b0, 1);
        chk("collide_err_count", err_count, 16'h0001);
        chk("collide_err_sticky", {15'd0, err_sticky}, 16'h0001);
        step(16'h1240, 1'b1, 1'b0, 1'b0, 1);
        chk("collide_next_count", err_count, 16'h0002);

        // Gapped enable: junk on disabled cycles must be ignored.
        for (int k = 0; k < 10; k++) begin
            v = 16'h1241 + 16'(k);
            step(v, 1'b1, 1'b0, 1'b0, 1);
            step(16'hDEAD, 1'b0, 1'b0, 1'b0, 1);
        end
        flush(2, 1);
        chk("gap_err_count", err_count, 16'h0002);
        chk("gap_last_sample", last_sample, 16'h124A);

        // Reset mid-lock, then clean relock.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            v = 16'h4000 + 16'(k);
            step(v, 1'b1, 1'b0, 1'b0, (k >= 4) ? 1 : 0);
        end
        flush(2, 1);
        chk("relock_err_count", err_count, 16'h0000);
        chk("relock_locked", {15'd0, locked}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
